// File: rtl/arc4_competition.sv
// arc4_competition: 24-bit ARC4 key search engine.
// Software starts a search by writing 8'hFF into mbox[0]. Keys are tried in
// ascending order. The first key that decrypts ct[1..ct[0]] to printable ASCII
// (8'h20..8'h7E) is reported in the mailbox and shown on HEX5..HEX0.
// Build option: define COMP_SEED_KEY_EN to seed the first key from SW[9:0].
module arc4_competition (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [9:0] LEDR
);
    localparam int unsigned KEY_W  = 24;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned SEG_W  = 7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_KSA   = 3'd2,
        S_PRGA  = 3'd3,
        S_NEXT  = 3'd4,
        S_FOUND = 3'd5,
        S_FAIL  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;

    // Engine clock is the board clock; KEY[3] is the synchronous active-low reset.
    logic fst_clk;
    logic rst_n;
    assign fst_clk = CLOCK_50;
    assign rst_n   = KEY[3];

    state_t              pstate;
    logic [KEY_W-1:0]    key;
    logic [BYTE_W-1:0]   mbox [8];
    logic [BYTE_W-1:0]   s    [256];
    // Ciphertext memory, preloaded externally; empty message at power-up.
    logic [BYTE_W-1:0]   ct   [256] = '{default: 8'h00};

    logic [BYTE_W-1:0]   i;
    logic [BYTE_W-1:0]   j;
    logic [BYTE_W-1:0]   cnt;
    logic [1:0]          ph;
    logic [1:0]          kidx;
    logic                found;
    logic                fail;
    logic [SEG_W-1:0]    hex [6];

    logic [KEY_W-1:0]    start_key;
    logic [BYTE_W-1:0]   kbyte;
    logic [BYTE_W-1:0]   si;
    logic [BYTE_W-1:0]   sj;
    logic [BYTE_W-1:0]   ks;
    logic [BYTE_W-1:0]   p;
    logic                printable;

`ifdef COMP_SEED_KEY_EN
    assign start_key = {SW, 14'h0000};
    logic unused_in;
    assign unused_in = &{1'b0, KEY[2:0]};
`else
    assign start_key = '0;
    logic unused_in;
    assign unused_in = &{1'b0, KEY[2:0], SW};
`endif

    // Key byte used by the schedule: k[i mod 3], tracked by kidx.
    always_comb begin
        kbyte = key[7:0];
        case (kidx)
            2'd0:    kbyte = key[23:16];
            2'd1:    kbyte = key[15:8];
            default: kbyte = key[7:0];
        endcase
    end

    assign si        = s[i];
    assign sj        = s[j];
    assign ks        = s[BYTE_W'(si + sj)];
    assign p         = ks ^ ct[BYTE_W'(cnt + 8'd1)];
    assign printable = (p >= 8'h20) && (p <= 8'h7E);

    function automatic logic [SEG_W-1:0] seg7(input logic [3:0] d);
        case (d)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'h5:    return 7'b0010010;
            4'h6:    return 7'b0000010;
            4'h7:    return 7'b1111000;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0010000;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b0000011;
            4'hC:    return 7'b1000110;
            4'hD:    return 7'b0100001;
            4'hE:    return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Search controller: INIT fills s, KSA mixes the key, PRGA tests each byte.
    always_ff @(posedge fst_clk) begin
        if (!rst_n) begin
            pstate <= S_IDLE;
            key    <= '0;
            i      <= '0;
            j      <= '0;
            cnt    <= '0;
            ph     <= '0;
            kidx   <= '0;
            found  <= 1'b0;
            fail   <= 1'b0;
            for (int n = 0; n < 8; n++) mbox[n] <= '0;
            for (int n = 0; n < 6; n++) hex[n]  <= SEG_BLANK;
        end else begin
            case (pstate)
                S_IDLE: begin
                    if (mbox[0] == 8'hFF) begin
                        mbox[0] <= '0;
                        key     <= start_key;
                        i       <= '0;
                        pstate  <= S_INIT;
                    end
                end
                S_INIT: begin
                    s[i] <= i;
                    i    <= i + 8'd1;
                    if (i == 8'hFF) begin
                        j      <= '0;
                        ph     <= '0;
                        kidx   <= '0;
                        pstate <= S_KSA;
                    end
                end
                S_KSA: begin
                    if (ph == 2'd0) begin
                        j  <= j + si + kbyte;
                        ph <= 2'd1;
                    end else begin
                        s[i] <= sj;
                        s[j] <= si;
                        i    <= i + 8'd1;
                        kidx <= (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
                        ph   <= 2'd0;
                        if (i == 8'hFF) begin
                            j      <= '0;
                            cnt    <= '0;
                            pstate <= S_PRGA;
                        end
                    end
                end
                S_PRGA: begin
                    case (ph)
                        2'd0: begin
                            if (cnt == ct[0]) begin
                                pstate <= S_FOUND;
                            end else begin
                                i  <= i + 8'd1;
                                ph <= 2'd1;
                            end
                        end
                        2'd1: begin
                            j  <= j + si;
                            ph <= 2'd2;
                        end
                        2'd2: begin
                            s[i] <= sj;
                            s[j] <= si;
                            ph   <= 2'd3;
                        end
                        default: begin
                            ph <= 2'd0;
                            if (printable) cnt    <= cnt + 8'd1;
                            else           pstate <= S_NEXT;
                        end
                    endcase
                end
                S_NEXT: begin
                    if (key == 24'hFFFFFF) begin
                        pstate <= S_FAIL;
                    end else begin
                        key    <= key + 24'd1;
                        i      <= '0;
                        pstate <= S_INIT;
                    end
                end
                S_FOUND: begin
                    mbox[1] <= 8'hFF;
                    mbox[2] <= key[23:16];
                    mbox[3] <= key[15:8];
                    mbox[4] <= key[7:0];
                    found   <= 1'b1;
                    hex[5]  <= seg7(key[23:20]);
                    hex[4]  <= seg7(key[19:16]);
                    hex[3]  <= seg7(key[15:12]);
                    hex[2]  <= seg7(key[11:8]);
                    hex[1]  <= seg7(key[7:4]);
                    hex[0]  <= seg7(key[3:0]);
                    pstate  <= S_DONE;
                end
                S_FAIL: begin
                    mbox[1] <= 8'hEE;
                    fail    <= 1'b1;
                    for (int n = 0; n < 6; n++) hex[n] <= SEG_DASH;
                    pstate  <= S_DONE;
                end
                S_DONE: begin
                    pstate <= S_DONE;
                end
            endcase
        end
    end

    assign HEX0 = hex[0];
    assign HEX1 = hex[1];
    assign HEX2 = hex[2];
    assign HEX3 = hex[3];
    assign HEX4 = hex[4];
    assign HEX5 = hex[5];
    assign LEDR = {3'b000, pstate, 2'b00, fail, found};

endmodule

// File: tb/tb_arc4_competition.sv
// Bench for arc4_competition: random ciphertexts and start keys checked against
// a straightforward ARC4 model and a linear key-search model.
module tb_arc4_competition;
    logic       clk = 1'b0;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0] LEDR;

    always #10 clk = ~clk;

    arc4_competition dut (
        .CLOCK_50 (clk),
        .KEY      (KEY),
        .SW       (SW),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5),
        .LEDR     (LEDR)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] mct [256];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] tab [16];
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tab[d];
    endfunction

    function automatic logic [23:0] start_of(input logic [9:0] sw);
`ifdef COMP_SEED_KEY_EN
        return {sw, 14'h0000};
`else
        return (sw == 10'h3FF) ? 24'h0 : 24'h0;
`endif
    endfunction

    // Plain ARC4: true when every decrypted byte of mct[1..mct[0]] is printable.
    function automatic bit rc4_printable(input logic [23:0] k);
        int st [256];
        int kb [3];
        int a, b, t, len;
        kb[0] = int'(k[23:16]);
        kb[1] = int'(k[15:8]);
        kb[2] = int'(k[7:0]);
        for (int n = 0; n < 256; n++) st[n] = n;
        b = 0;
        for (int n = 0; n < 256; n++) begin
            b = (b + st[n] + kb[n % 3]) % 256;
            t = st[n]; st[n] = st[b]; st[b] = t;
        end
        a = 0; b = 0;
        len = int'(mct[0]);
        for (int n = 1; n <= len; n++) begin
            a = (a + 1) % 256;
            b = (b + st[a]) % 256;
            t = st[a]; st[a] = st[b]; st[b] = t;
            t = st[(st[a] + st[b]) % 256] ^ int'(mct[n]);
            if (t < 32 || t > 126) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Linear search from start; stops on success, at key FFFFFF, or after limit keys.
    task automatic model_search(input logic [23:0] start, input int limit,
                                output bit found, output bit exhausted, output logic [23:0] k);
        found = 1'b0; exhausted = 1'b0; k = start;
        for (int n = 0; n < limit; n++) begin
            if (rc4_printable(k)) begin found = 1'b1; return; end
            if (k == 24'hFFFFFF) begin exhausted = 1'b1; return; end
            k = k + 24'd1;
        end
    endtask

    task automatic load_ct();
        for (int n = 0; n < 256; n++) dut.ct[n] = mct[n];
    endtask

    task automatic do_reset();
        @(negedge clk);
        KEY = 4'b0111;
        repeat (3) @(negedge clk);
        KEY = 4'b1111;
    endtask

    // Start a search; optionally replace the first candidate key while INIT runs.
    task automatic run_search(input string tag, input bit do_ovr, input logic [23:0] ovr,
                              input int budget);
        @(negedge clk);
        dut.mbox[0] = 8'hFF;
        @(negedge clk);
        if (do_ovr) dut.key = ovr;
        repeat (300) @(negedge clk);
        dut.mbox[0] = 8'hFF;
        for (int c = 0; c < budget && 3'(dut.pstate) != 3'd7; c++) @(negedge clk);
        check({tag, "_done"}, 32'(dut.pstate), 32'd7);
    endtask

    task automatic check_result(input string tag, input bit ef, input logic [23:0] ek);
        check({tag, "_mbox1"}, 32'(dut.mbox[1]), ef ? 32'hFF : 32'hEE);
        check({tag, "_key"},   32'(dut.key), 32'(ek));
        if (ef) begin
            check({tag, "_mbox2"}, 32'(dut.mbox[2]), 32'(ek[23:16]));
            check({tag, "_mbox3"}, 32'(dut.mbox[3]), 32'(ek[15:8]));
            check({tag, "_mbox4"}, 32'(dut.mbox[4]), 32'(ek[7:0]));
            check({tag, "_hex5"}, 32'(HEX5), 32'(seg_of(ek[23:20])));
            check({tag, "_hex4"}, 32'(HEX4), 32'(seg_of(ek[19:16])));
            check({tag, "_hex3"}, 32'(HEX3), 32'(seg_of(ek[15:12])));
            check({tag, "_hex2"}, 32'(HEX2), 32'(seg_of(ek[11:8])));
            check({tag, "_hex1"}, 32'(HEX1), 32'(seg_of(ek[7:4])));
            check({tag, "_hex0"}, 32'(HEX0), 32'(seg_of(ek[3:0])));
            check({tag, "_ledr"}, 32'(LEDR), 32'h071);
        end else begin
            check({tag, "_hex"}, 32'({HEX5, HEX4, HEX3, HEX2}), 32'({4{7'b0111111}}));
            check({tag, "_hexlo"}, 32'({HEX1, HEX0}), 32'({2{7'b0111111}}));
            check({tag, "_ledr"}, 32'(LEDR), 32'h072);
        end
        check({tag, "_rc4"}, 32'(ef ? rc4_printable(dut.key) : 1'b1), 32'd1);
    endtask

    initial begin
        bit          ef, ex, ok;
        logic [23:0] ek, st;
        logic [9:0]  sw_v;

        KEY = 4'b0111;
        SW  = '0;
        for (int n = 0; n < 256; n++) mct[n] = 8'h00;
        do_reset();
        @(negedge clk);

        // Reset state and idle hold
        check("rst_pstate", 32'(dut.pstate), 32'd0);
        check("rst_key",    32'(dut.key), 32'd0);
        check("rst_ledr",   32'(LEDR), 32'd0);
        check("rst_hex",    32'({HEX5, HEX4, HEX3, HEX2}), 32'({4{7'h7F}}));
        check("rst_hexlo",  32'({HEX1, HEX0}), 32'({2{7'h7F}}));
        for (int n = 0; n < 8; n++) check($sformatf("rst_mbox%0d", n), 32'(dut.mbox[n]), 32'd0);
        repeat (20) @(negedge clk);
        check("idle_hold", 32'(dut.pstate), 32'd0);

        // Empty message: found at the start key with exact phase timing
        sw_v = 10'($urandom);
        SW   = sw_v;
        load_ct();
        @(negedge clk);
        dut.mbox[0] = 8'hFF;
        @(negedge clk);
        check("start_seen", 32'(dut.pstate), 32'd1);
        check("start_clr",  32'(dut.mbox[0]), 32'd0);
        repeat (255) @(negedge clk);
        check("init_end", 32'(dut.pstate), 32'd1);
        @(negedge clk);
        check("ksa_begin", 32'(dut.pstate), 32'd2);
        repeat (512) @(negedge clk);
        check("prga_begin", 32'(dut.pstate), 32'd3);
        @(negedge clk);
        check("found_state", 32'(dut.pstate), 32'd5);
        @(negedge clk);
        check("empty_done", 32'(dut.pstate), 32'd7);
        check_result("empty", 1'b1, start_of(sw_v));

        // Start command while DONE is ignored
        dut.mbox[0] = 8'hFF;
        repeat (10) @(negedge clk);
        check("done_hold", 32'(dut.pstate), 32'd7);
        check_result("done_hold", 1'b1, start_of(sw_v));
        SW = '0;

        // Known vector: key "Key" decrypts this to "Plaintext"
        do_reset();
        mct[0] = 8'h09;
        mct[1] = 8'hBB; mct[2] = 8'hF3; mct[3] = 8'h16; mct[4] = 8'hE8; mct[5] = 8'hD9;
        mct[6] = 8'h40; mct[7] = 8'hAF; mct[8] = 8'h0A; mct[9] = 8'hD3;
        load_ct();
        model_search(24'h4B6570, 16, ef, ex, ek);
        check("vec_model_le", 32'(ek <= 24'h4B6579), 32'd1);
        run_search("vec", 1'b1, 24'h4B6570, 20000);
        check_result("vec", ef, ek);

        // Random two-byte messages from random start keys, then reset mid-KSA
        for (int r = 0; r < 2; r++) begin
            ef = 1'b0;
            st = '0;
            for (int t = 0; t < 50 && !ef; t++) begin
                for (int n = 0; n < 256; n++) mct[n] = 8'($urandom);
                mct[0] = 8'd2;
                st = 24'($urandom_range(0, 32'hFFFF00));
                model_search(st, 12, ef, ex, ek);
            end
            do_reset();
            load_ct();
            run_search($sformatf("rnd%0d", r), 1'b1, st, 12000);
            check_result($sformatf("rnd%0d", r), ef, ek);
        end

        do_reset();
        load_ct();
        @(negedge clk);
        dut.mbox[0] = 8'hFF;
        @(negedge clk);
        dut.key = st;
        for (int c = 0; c < 400 && 3'(dut.pstate) != 3'd2; c++) @(negedge clk);
        repeat (100) @(negedge clk);
        check("ksa_reached", 32'(dut.pstate), 32'd2);
        KEY = 4'b0111;
        @(negedge clk);
        KEY = 4'b1111;
        check("mid_rst_pstate", 32'(dut.pstate), 32'd0);
        check("mid_rst_key",    32'(dut.key), 32'd0);
        check("mid_rst_ledr",   32'(LEDR), 32'd0);
        for (int n = 0; n < 8; n++) check($sformatf("mid_rst_mbox%0d", n), 32'(dut.mbox[n]), 32'd0);
        run_search("rerun", 1'b1, st, 12000);
        check_result("rerun", ef, ek);

        // Exhaustion: last two keys both fail, search wraps to FAIL
        ok = 1'b0;
        for (int n = 0; n < 256; n++) mct[n] = 8'($urandom);
        mct[0] = 8'd1;
        for (int c = 0; c < 256 && !ok; c++) begin
            mct[1] = 8'(c);
            ok = !rc4_printable(24'hFFFFFE) && !rc4_printable(24'hFFFFFF);
        end
        mct[0] = 8'd255;
        model_search(24'hFFFFFE, 4, ef, ex, ek);
        check("fail_model", 32'({ef, ex}), 32'b01);
        do_reset();
        load_ct();
        run_search("fail", 1'b1, 24'hFFFFFE, 4000);
        check_result("fail", ef, ek);
        check("fail_mbox2", 32'(dut.mbox[2]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
